// File: rtl/sm4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sm4_pkg
//  Description : Shared SM4 definitions for the key schedule: FK system
//                parameters, round count, key-expansion FSM state encoding
//                and the L' linear transform used on round keys.
//  Revision    : 1.0 - initial release
// ============================================================================
package sm4_pkg;

    localparam int c_SM4_ROUNDS = 32;

    // FK0..FK3, XORed into MK0..MK3 on key acceptance
    localparam logic [31:0] c_FK0 = 32'hA3B1_BAC6;
    localparam logic [31:0] c_FK1 = 32'h56AA_3350;
    localparam logic [31:0] c_FK2 = 32'h677D_9197;
    localparam logic [31:0] c_FK3 = 32'hB270_22DC;

    // Rotation amounts of the key-schedule transform L'
    localparam int c_ROT_A = 13;
    localparam int c_ROT_B = 23;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } sm4_state_t;

    function automatic logic [31:0] sm4_rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // L'(B) = B ^ (B <<< 13) ^ (B <<< 23)
    function automatic logic [31:0] sm4_l_key(input logic [31:0] b);
        return b ^ sm4_rotl(b, c_ROT_A) ^ sm4_rotl(b, c_ROT_B);
    endfunction

endpackage : sm4_pkg
`default_nettype wire

// File: rtl/sm4_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : sm4_sbox
//  Description : Combinational SM4 8-bit substitution box. Shared between the
//                key schedule and the encrypt/decrypt datapath.
//  Ports       : i_din  [7:0]  input byte
//                o_dout [7:0]  substituted byte
//  Revision    : 1.0 - initial release
// ============================================================================
module sm4_sbox (
    input  logic [7:0] i_din,
    output logic [7:0] o_dout
);

    always_comb begin
        o_dout = 8'h00;
        case (i_din)
            8'h00: o_dout = 8'hD6;  8'h01: o_dout = 8'h90;  8'h02: o_dout = 8'hE9;  8'h03: o_dout = 8'hFE;
            8'h04: o_dout = 8'hCC;  8'h05: o_dout = 8'hE1;  8'h06: o_dout = 8'h3D;  8'h07: o_dout = 8'hB7;
            8'h08: o_dout = 8'h16;  8'h09: o_dout = 8'hB6;  8'h0A: o_dout = 8'h14;  8'h0B: o_dout = 8'hC2;
            8'h0C: o_dout = 8'h28;  8'h0D: o_dout = 8'hFB;  8'h0E: o_dout = 8'h2C;  8'h0F: o_dout = 8'h05;
            8'h10: o_dout = 8'h2B;  8'h11: o_dout = 8'h67;  8'h12: o_dout = 8'h9A;  8'h13: o_dout = 8'h76;
            8'h14: o_dout = 8'h2A;  8'h15: o_dout = 8'hBE;  8'h16: o_dout = 8'h04;  8'h17: o_dout = 8'hC3;
            8'h18: o_dout = 8'hAA;  8'h19: o_dout = 8'h44;  8'h1A: o_dout = 8'h13;  8'h1B: o_dout = 8'h26;
            8'h1C: o_dout = 8'h49;  8'h1D: o_dout = 8'h86;  8'h1E: o_dout = 8'h06;  8'h1F: o_dout = 8'h99;
            8'h20: o_dout = 8'h9C;  8'h21: o_dout = 8'h42;  8'h22: o_dout = 8'h50;  8'h23: o_dout = 8'hF4;
            8'h24: o_dout = 8'h91;  8'h25: o_dout = 8'hEF;  8'h26: o_dout = 8'h98;  8'h27: o_dout = 8'h7A;
            8'h28: o_dout = 8'h33;  8'h29: o_dout = 8'h54;  8'h2A: o_dout = 8'h0B;  8'h2B: o_dout = 8'h43;
            8'h2C: o_dout = 8'hED;  8'h2D: o_dout = 8'hCF;  8'h2E: o_dout = 8'hAC;  8'h2F: o_dout = 8'h62;
            8'h30: o_dout = 8'hE4;  8'h31: o_dout = 8'hB3;  8'h32: o_dout = 8'h1C;  8'h33: o_dout = 8'hA9;
            8'h34: o_dout = 8'hC9;  8'h35: o_dout = 8'h08;  8'h36: o_dout = 8'hE8;  8'h37: o_dout = 8'h95;
            8'h38: o_dout = 8'h80;  8'h39: o_dout = 8'hDF;  8'h3A: o_dout = 8'h94;  8'h3B: o_dout = 8'hFA;
            8'h3C: o_dout = 8'h75;  8'h3D: o_dout = 8'h8F;  8'h3E: o_dout = 8'h3F;  8'h3F: o_dout = 8'hA6;
            8'h40: o_dout = 8'h47;  8'h41: o_dout = 8'h07;  8'h42: o_dout = 8'hA7;  8'h43: o_dout = 8'hFC;
            8'h44: o_dout = 8'hF3;  8'h45: o_dout = 8'h73;  8'h46: o_dout = 8'h17;  8'h47: o_dout = 8'hBA;
            8'h48: o_dout = 8'h83;  8'h49: o_dout = 8'h59;  8'h4A: o_dout = 8'h3C;  8'h4B: o_dout = 8'h19;
            8'h4C: o_dout = 8'hE6;  8'h4D: o_dout = 8'h85;  8'h4E: o_dout = 8'h4F;  8'h4F: o_dout = 8'hA8;
            8'h50: o_dout = 8'h68;  8'h51: o_dout = 8'h6B;  8'h52: o_dout = 8'h81;  8'h53: o_dout = 8'hB2;
            8'h54: o_dout = 8'h71;  8'h55: o_dout = 8'h64;  8'h56: o_dout = 8'hDA;  8'h57: o_dout = 8'h8B;
            8'h58: o_dout = 8'hF8;  8'h59: o_dout = 8'hEB;  8'h5A: o_dout = 8'h0F;  8'h5B: o_dout = 8'h4B;
            8'h5C: o_dout = 8'h70;  8'h5D: o_dout = 8'h56;  8'h5E: o_dout = 8'h9D;  8'h5F: o_dout = 8'h35;
            8'h60: o_dout = 8'h1E;  8'h61: o_dout = 8'h24;  8'h62: o_dout = 8'h0E;  8'h63: o_dout = 8'h5E;
            8'h64: o_dout = 8'h63;  8'h65: o_dout = 8'h58;  8'h66: o_dout = 8'hD1;  8'h67: o_dout = 8'hA2;
            8'h68: o_dout = 8'h25;  8'h69: o_dout = 8'h22;  8'h6A: o_dout = 8'h7C;  8'h6B: o_dout = 8'h3B;
            8'h6C: o_dout = 8'h01;  8'h6D: o_dout = 8'h21;  8'h6E: o_dout = 8'h78;  8'h6F: o_dout = 8'h87;
            8'h70: o_dout = 8'hD4;  8'h71: o_dout = 8'h00;  8'h72: o_dout = 8'h46;  8'h73: o_dout = 8'h57;
            8'h74: o_dout = 8'h9F;  8'h75: o_dout = 8'hD3;  8'h76: o_dout = 8'h27;  8'h77: o_dout = 8'h52;
            8'h78: o_dout = 8'h4C;  8'h79: o_dout = 8'h36;  8'h7A: o_dout = 8'h02;  8'h7B: o_dout = 8'hE7;
            8'h7C: o_dout = 8'hA0;  8'h7D: o_dout = 8'hC4;  8'h7E: o_dout = 8'hC8;  8'h7F: o_dout = 8'h9E;
            8'h80: o_dout = 8'hEA;  8'h81: o_dout = 8'hBF;  8'h82: o_dout = 8'h8A;  8'h83: o_dout = 8'hD2;
            8'h84: o_dout = 8'h40;  8'h85: o_dout = 8'hC7;  8'h86: o_dout = 8'h38;  8'h87: o_dout = 8'hB5;
            8'h88: o_dout = 8'hA3;  8'h89: o_dout = 8'hF7;  8'h8A: o_dout = 8'hF2;  8'h8B: o_dout = 8'hCE;
            8'h8C: o_dout = 8'hF9;  8'h8D: o_dout = 8'h61;  8'h8E: o_dout = 8'h15;  8'h8F: o_dout = 8'hA1;
            8'h90: o_dout = 8'hE0;  8'h91: o_dout = 8'hAE;  8'h92: o_dout = 8'h5D;  8'h93: o_dout = 8'hA4;
            8'h94: o_dout = 8'h9B;  8'h95: o_dout = 8'h34;  8'h96: o_dout = 8'h1A;  8'h97: o_dout = 8'h55;
            8'h98: o_dout = 8'hAD;  8'h99: o_dout = 8'h93;  8'h9A: o_dout = 8'h32;  8'h9B: o_dout = 8'h30;
            8'h9C: o_dout = 8'hF5;  8'h9D: o_dout = 8'h8C;  8'h9E: o_dout = 8'hB1;  8'h9F: o_dout = 8'hE3;
            8'hA0: o_dout = 8'h1D;  8'hA1: o_dout = 8'hF6;  8'hA2: o_dout = 8'hE2;  8'hA3: o_dout = 8'h2E;
            8'hA4: o_dout = 8'h82;  8'hA5: o_dout = 8'h66;  8'hA6: o_dout = 8'hCA;  8'hA7: o_dout = 8'h60;
            8'hA8: o_dout = 8'hC0;  8'hA9: o_dout = 8'h29;  8'hAA: o_dout = 8'h23;  8'hAB: o_dout = 8'hAB;
            8'hAC: o_dout = 8'h0D;  8'hAD: o_dout = 8'h53;  8'hAE: o_dout = 8'h4E;  8'hAF: o_dout = 8'h6F;
            8'hB0: o_dout = 8'hD5;  8'hB1: o_dout = 8'hDB;  8'hB2: o_dout = 8'h37;  8'hB3: o_dout = 8'h45;
            8'hB4: o_dout = 8'hDE;  8'hB5: o_dout = 8'hFD;  8'hB6: o_dout = 8'h8E;  8'hB7: o_dout = 8'h2F;
            8'hB8: o_dout = 8'h03;  8'hB9: o_dout = 8'hFF;  8'hBA: o_dout = 8'h6A;  8'hBB: o_dout = 8'h72;
            8'hBC: o_dout = 8'h6D;  8'hBD: o_dout = 8'h6C;  8'hBE: o_dout = 8'h5B;  8'hBF: o_dout = 8'h51;
            8'hC0: o_dout = 8'h8D;  8'hC1: o_dout = 8'h1B;  8'hC2: o_dout = 8'hAF;  8'hC3: o_dout = 8'h92;
            8'hC4: o_dout = 8'hBB;  8'hC5: o_dout = 8'hDD;  8'hC6: o_dout = 8'hBC;  8'hC7: o_dout = 8'h7F;
            8'hC8: o_dout = 8'h11;  8'hC9: o_dout = 8'hD9;  8'hCA: o_dout = 8'h5C;  8'hCB: o_dout = 8'h41;
            8'hCC: o_dout = 8'h1F;  8'hCD: o_dout = 8'h10;  8'hCE: o_dout = 8'h5A;  8'hCF: o_dout = 8'hD8;
            8'hD0: o_dout = 8'h0A;  8'hD1: o_dout = 8'hC1;  8'hD2: o_dout = 8'h31;  8'hD3: o_dout = 8'h88;
            8'hD4: o_dout = 8'hA5;  8'hD5: o_dout = 8'hCD;  8'hD6: o_dout = 8'h7B;  8'hD7: o_dout = 8'hBD;
            8'hD8: o_dout = 8'h2D;  8'hD9: o_dout = 8'h74;  8'hDA: o_dout = 8'hD0;  8'hDB: o_dout = 8'h12;
            8'hDC: o_dout = 8'hB8;  8'hDD: o_dout = 8'hE5;  8'hDE: o_dout = 8'hB4;  8'hDF: o_dout = 8'hB0;
            8'hE0: o_dout = 8'h89;  8'hE1: o_dout = 8'h69;  8'hE2: o_dout = 8'h97;  8'hE3: o_dout = 8'h4A;
            8'hE4: o_dout = 8'h0C;  8'hE5: o_dout = 8'h96;  8'hE6: o_dout = 8'h77;  8'hE7: o_dout = 8'h7E;
            8'hE8: o_dout = 8'h65;  8'hE9: o_dout = 8'hB9;  8'hEA: o_dout = 8'hF1;  8'hEB: o_dout = 8'h09;
            8'hEC: o_dout = 8'hC5;  8'hED: o_dout = 8'h6E;  8'hEE: o_dout = 8'hC6;  8'hEF: o_dout = 8'h84;
            8'hF0: o_dout = 8'h18;  8'hF1: o_dout = 8'hF0;  8'hF2: o_dout = 8'h7D;  8'hF3: o_dout = 8'hEC;
            8'hF4: o_dout = 8'h3A;  8'hF5: o_dout = 8'hDC;  8'hF6: o_dout = 8'h4D;  8'hF7: o_dout = 8'h20;
            8'hF8: o_dout = 8'h79;  8'hF9: o_dout = 8'hEE;  8'hFA: o_dout = 8'h5F;  8'hFB: o_dout = 8'h3E;
            8'hFC: o_dout = 8'hD7;  8'hFD: o_dout = 8'hCB;  8'hFE: o_dout = 8'h39;  8'hFF: o_dout = 8'h48;
            default: o_dout = 8'h00;
        endcase
    end

endmodule : sm4_sbox
`default_nettype wire

// File: rtl/sm4_key_expand.sv
`default_nettype none
// ============================================================================
//  Module      : sm4_key_expand
//  Description : SM4 key-expansion engine. Accepts a 128-bit master key,
//                walks the external CK table through sm4_round_cnt (CK
//                returns one clock later) and produces rk0..rk31 into a
//                32x32 round-key file read forward (encrypt) or reversed
//                (decrypt) with one cycle of read latency.
//  Ports       : clk_sys        in   system clock
//                rst_n          in   synchronous active-low reset
//                key_in[127:0]  in   MK, MK0 in [127:96]
//                key_valid      in   key_in valid
//                key_ready      out  ready to accept a key (IDLE / DONE)
//                sm4_round_cnt  out  CK index to the CK table
//                sm4_key_cki    in   CK[sm4_round_cnt] from the prior cycle
//                key_done       out  round-key file complete (level)
//                rk_rd_idx      in   round-key read index
//                rk_rd_dec      in   1: read rk[31-idx], 0: read rk[idx]
//                rk_rd_data     out  registered read data, 0 unless done
//                key_zeroize    in   clear all key material (optional)
//  Config      : SM4_KEY_ZEROIZE_EN - adds key_zeroize and the clear path
//  Revision    : 1.0 - initial release
// ============================================================================
module sm4_key_expand
    import sm4_pkg::*;
#(
    parameter int RK_W     = 32,
    parameter int N_ROUNDS = c_SM4_ROUNDS
) (
    input  logic                        clk_sys,
    input  logic                        rst_n,
    input  logic [4*RK_W-1:0]           key_in,
    input  logic                        key_valid,
    output logic                        key_ready,
    output logic [$clog2(N_ROUNDS)-1:0] sm4_round_cnt,
    input  logic [RK_W-1:0]             sm4_key_cki,
    output logic                        key_done,
    input  logic [$clog2(N_ROUNDS)-1:0] rk_rd_idx,
    input  logic                        rk_rd_dec,
`ifdef SM4_KEY_ZEROIZE_EN
    input  logic                        key_zeroize,
`endif
    output logic [RK_W-1:0]             rk_rd_data
);

    localparam int c_IDX_W = $clog2(N_ROUNDS);

    sm4_state_t          r_state;
    logic                r_key_ready;
    logic                r_key_done;
    logic [c_IDX_W-1:0]  r_round_cnt;
    logic [c_IDX_W-1:0]  r_rnd;
    logic [RK_W-1:0]     r_k0, r_k1, r_k2, r_k3;
    logic [RK_W-1:0]     r_rd_data;
    logic [RK_W-1:0]     r_rk_file [N_ROUNDS];

    logic                w_zeroize;
    logic                w_accept;
    logic                w_rk_we;
    logic [RK_W-1:0]     w_t;
    logic [RK_W-1:0]     w_tau;
    logic [RK_W-1:0]     w_rk;
    logic [c_IDX_W-1:0]  w_rd_phys;

`ifdef SM4_KEY_ZEROIZE_EN
    assign w_zeroize = key_zeroize;
`else
    assign w_zeroize = 1'b0;
`endif

    assign w_accept  = key_valid && r_key_ready;
    assign w_rk_we   = rst_n && !w_zeroize && (r_state == ST_ROUND);
    assign w_rd_phys = rk_rd_dec ? (c_IDX_W'(N_ROUNDS - 1) - rk_rd_idx) : rk_rd_idx;

    // Round function of the key schedule: rk = K0 ^ L'(tau(K1^K2^K3^CK))
    assign w_t = r_k1 ^ r_k2 ^ r_k3 ^ sm4_key_cki;

    genvar gi;
    generate
        for (gi = 0; gi < RK_W / 8; gi++) begin : g_sbox
            sm4_sbox u_sbox (
                .i_din  (w_t[8*gi +: 8]),
                .o_dout (w_tau[8*gi +: 8])
            );
        end
    endgenerate

    assign w_rk = r_k0 ^ sm4_l_key(w_tau);

    // Control FSM, key shift register and registered read port
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_key_ready <= 1'b0;
            r_key_done  <= 1'b0;
            r_round_cnt <= '0;
            r_rnd       <= '0;
            r_rd_data   <= '0;
            r_k0        <= '0;
            r_k1        <= '0;
            r_k2        <= '0;
            r_k3        <= '0;
        end else if (w_zeroize) begin
            r_state     <= ST_IDLE;
            r_key_ready <= 1'b1;
            r_key_done  <= 1'b0;
            r_round_cnt <= '0;
            r_rnd       <= '0;
            r_rd_data   <= '0;
            r_k0        <= '0;
            r_k1        <= '0;
            r_k2        <= '0;
            r_k3        <= '0;
        end else begin
            // Masking uses the done flag as it stands at this edge, so the
            // cycle after a new accept still returns old data exactly once.
            r_rd_data <= r_key_done ? r_rk_file[w_rd_phys] : '0;

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_key_ready <= 1'b1;
                    if (w_accept) begin
                        r_k0        <= key_in[4*RK_W-1 -: RK_W] ^ c_FK0;
                        r_k1        <= key_in[3*RK_W-1 -: RK_W] ^ c_FK1;
                        r_k2        <= key_in[2*RK_W-1 -: RK_W] ^ c_FK2;
                        r_k3        <= key_in[1*RK_W-1 -: RK_W] ^ c_FK3;
                        r_round_cnt <= '0;
                        r_key_done  <= 1'b0;
                        r_key_ready <= 1'b0;
                        r_state     <= ST_PRIME;
                    end
                end

                // CK table latency slot: index 0 is in flight, nothing to compute
                ST_PRIME: begin
                    r_round_cnt <= c_IDX_W'(1);
                    r_rnd       <= '0;
                    r_state     <= ST_ROUND;
                end

                ST_ROUND: begin
                    r_k0  <= r_k1;
                    r_k1  <= r_k2;
                    r_k2  <= r_k3;
                    r_k3  <= w_rk;
                    r_rnd <= r_rnd + c_IDX_W'(1);
                    // Request runs two ahead of the round being computed
                    r_round_cnt <= r_rnd + c_IDX_W'(2);
                    if (r_rnd == c_IDX_W'(N_ROUNDS - 1)) begin
                        r_round_cnt <= '0;
                        r_key_done  <= 1'b1;
                        r_key_ready <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_key_ready <= 1'b0;
                end
            endcase
        end
    end

    // Round-key file: deliberately outside reset; only zeroize clears it
    always_ff @(posedge clk_sys) begin
        if (w_zeroize) begin
            for (int i = 0; i < N_ROUNDS; i++) begin
                r_rk_file[i] <= '0;
            end
        end else if (w_rk_we) begin
            r_rk_file[r_rnd] <= w_rk;
        end
    end

    assign key_ready     = r_key_ready;
    assign key_done      = r_key_done;
    assign sm4_round_cnt = r_round_cnt;
    assign rk_rd_data    = r_rd_data;

endmodule : sm4_key_expand
`default_nettype wire

// File: tb/tb_sm4_key_expand.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sm4_key_expand
//  Description : Self-checking bench for sm4_key_expand. Provides a
//                registered CK table, an independent key-schedule model and
//                a read scoreboard comparing rk_rd_data one cycle after
//                each read request.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sm4_key_expand;

    localparam logic [127:0] c_V1 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] c_V2 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] c_V3 = 128'hDEADBEEF_0BADF00D_CAFEBABE_13579BDF;

    localparam logic [7:0] c_SBOX [256] = '{
        8'hD6,8'h90,8'hE9,8'hFE,8'hCC,8'hE1,8'h3D,8'hB7,8'h16,8'hB6,8'h14,8'hC2,8'h28,8'hFB,8'h2C,8'h05,
        8'h2B,8'h67,8'h9A,8'h76,8'h2A,8'hBE,8'h04,8'hC3,8'hAA,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
        8'h9C,8'h42,8'h50,8'hF4,8'h91,8'hEF,8'h98,8'h7A,8'h33,8'h54,8'h0B,8'h43,8'hED,8'hCF,8'hAC,8'h62,
        8'hE4,8'hB3,8'h1C,8'hA9,8'hC9,8'h08,8'hE8,8'h95,8'h80,8'hDF,8'h94,8'hFA,8'h75,8'h8F,8'h3F,8'hA6,
        8'h47,8'h07,8'hA7,8'hFC,8'hF3,8'h73,8'h17,8'hBA,8'h83,8'h59,8'h3C,8'h19,8'hE6,8'h85,8'h4F,8'hA8,
        8'h68,8'h6B,8'h81,8'hB2,8'h71,8'h64,8'hDA,8'h8B,8'hF8,8'hEB,8'h0F,8'h4B,8'h70,8'h56,8'h9D,8'h35,
        8'h1E,8'h24,8'h0E,8'h5E,8'h63,8'h58,8'hD1,8'hA2,8'h25,8'h22,8'h7C,8'h3B,8'h01,8'h21,8'h78,8'h87,
        8'hD4,8'h00,8'h46,8'h57,8'h9F,8'hD3,8'h27,8'h52,8'h4C,8'h36,8'h02,8'hE7,8'hA0,8'hC4,8'hC8,8'h9E,
        8'hEA,8'hBF,8'h8A,8'hD2,8'h40,8'hC7,8'h38,8'hB5,8'hA3,8'hF7,8'hF2,8'hCE,8'hF9,8'h61,8'h15,8'hA1,
        8'hE0,8'hAE,8'h5D,8'hA4,8'h9B,8'h34,8'h1A,8'h55,8'hAD,8'h93,8'h32,8'h30,8'hF5,8'h8C,8'hB1,8'hE3,
        8'h1D,8'hF6,8'hE2,8'h2E,8'h82,8'h66,8'hCA,8'h60,8'hC0,8'h29,8'h23,8'hAB,8'h0D,8'h53,8'h4E,8'h6F,
        8'hD5,8'hDB,8'h37,8'h45,8'hDE,8'hFD,8'h8E,8'h2F,8'h03,8'hFF,8'h6A,8'h72,8'h6D,8'h6C,8'h5B,8'h51,
        8'h8D,8'h1B,8'hAF,8'h92,8'hBB,8'hDD,8'hBC,8'h7F,8'h11,8'hD9,8'h5C,8'h41,8'h1F,8'h10,8'h5A,8'hD8,
        8'h0A,8'hC1,8'h31,8'h88,8'hA5,8'hCD,8'h7B,8'hBD,8'h2D,8'h74,8'hD0,8'h12,8'hB8,8'hE5,8'hB4,8'hB0,
        8'h89,8'h69,8'h97,8'h4A,8'h0C,8'h96,8'h77,8'h7E,8'h65,8'hB9,8'hF1,8'h09,8'hC5,8'h6E,8'hC6,8'h84,
        8'h18,8'hF0,8'h7D,8'hEC,8'h3A,8'hDC,8'h4D,8'h20,8'h79,8'hEE,8'h5F,8'h3E,8'hD7,8'hCB,8'h39,8'h48
    };

    logic         clk_sys = 1'b0;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [4:0]   sm4_round_cnt;
    logic [31:0]  sm4_key_cki;
    logic         key_done;
    logic [4:0]   rk_rd_idx;
    logic         rk_rd_dec;
    logic [31:0]  rk_rd_data;
`ifdef SM4_KEY_ZEROIZE_EN
    logic         key_zeroize;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_rk [32];

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } rd_exp_t;
    rd_exp_t rd_q [$];
    logic    tb_rd_issue;
    logic    mon_pend;
    rd_exp_t mon_e;

    sm4_key_expand dut (
        .clk_sys       (clk_sys),
        .rst_n         (rst_n),
        .key_in        (key_in),
        .key_valid     (key_valid),
        .key_ready     (key_ready),
        .sm4_round_cnt (sm4_round_cnt),
        .sm4_key_cki   (sm4_key_cki),
        .key_done      (key_done),
        .rk_rd_idx     (rk_rd_idx),
        .rk_rd_dec     (rk_rd_dec),
`ifdef SM4_KEY_ZEROIZE_EN
        .key_zeroize   (key_zeroize),
`endif
        .rk_rd_data    (rk_rd_data)
    );

    always #5 clk_sys = ~clk_sys;

    // CK[i] byte j = (4i+j)*7 mod 256, MSB first
    function automatic logic [31:0] ck_word(input int i);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) begin
            w[31-8*j -: 8] = 8'(((4 * i) + j) * 7);
        end
        return w;
    endfunction

    // Registered CK table, one cycle of latency
    always @(posedge clk_sys) sm4_key_cki <= ck_word(int'(sm4_round_cnt));

    function automatic logic [31:0] tau_l(input logic [31:0] x);
        logic [31:0] b;
        b = {c_SBOX[x[31:24]], c_SBOX[x[23:16]], c_SBOX[x[15:8]], c_SBOX[x[7:0]]};
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

    task automatic model_expand(input logic [127:0] mk);
        logic [31:0] k [4];
        logic [31:0] rk;
        k[0] = mk[127:96] ^ 32'hA3B1BAC6;
        k[1] = mk[95:64]  ^ 32'h56AA3350;
        k[2] = mk[63:32]  ^ 32'h677D9197;
        k[3] = mk[31:0]   ^ 32'hB27022DC;
        for (int r = 0; r < 32; r++) begin
            rk = k[0] ^ tau_l(k[1] ^ k[2] ^ k[3] ^ ck_word(r));
            m_rk[r] = rk;
            k[0] = k[1]; k[1] = k[2]; k[2] = k[3]; k[3] = rk;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Scoreboard monitor: compares the read result one edge after the request
    always @(posedge clk_sys) begin
        mon_pend = tb_rd_issue;
        #1;
        if (mon_pend) begin
            if (rd_q.size() == 0) begin
                chk("rd_queue_underflow", 32'd0, 32'd1);
            end else begin
                mon_e = rd_q.pop_front();
                chk(mon_e.tag, rk_rd_data, mon_e.exp);
            end
        end
    end

    task automatic rd(input logic [4:0] idx, input logic dec, input logic [31:0] exp, input string tag);
        @(negedge clk_sys);
        rk_rd_idx   = idx;
        rk_rd_dec   = dec;
        tb_rd_issue = 1'b1;
        rd_q.push_back('{tag: tag, exp: exp});
    endtask

    task automatic rd_drain();
        @(negedge clk_sys);
        tb_rd_issue = 1'b0;
        @(posedge clk_sys);
        #2;
        chk("rd_queue_empty", 32'(rd_q.size()), 32'd0);
    endtask

    // Returns at #1 after the accepting edge
    task automatic send_key(input logic [127:0] mk);
        int n = 0;
        @(negedge clk_sys);
        key_in    = mk;
        key_valid = 1'b1;
        while (!key_ready && n < 20) begin
            @(negedge clk_sys);
            n++;
        end
        chk("accept_ready", 32'(key_ready), 32'd1);
        @(posedge clk_sys);
        #1;
        key_valid = 1'b0;
    endtask

    // Follows one expansion from the accept edge through key_done
    task automatic run_expand(input bit busy_test);
        bit trace_ok;
        trace_ok = (sm4_round_cnt === 5'd0);
        for (int j = 1; j <= 33; j++) begin
            @(posedge clk_sys);
            #1;
            if (j <= 31 && sm4_round_cnt !== 5'(j)) trace_ok = 1'b0;
            if (busy_test && j == 9) begin
                chk("busy_ready_low", 32'(key_ready), 32'd0);
                key_in    = c_V3;
                key_valid = 1'b1;
            end
            if (busy_test && j == 10) key_valid = 1'b0;
            if (j == 32) chk("done_not_early", 32'(key_done), 32'd0);
            if (j == 33) chk("done_at_a34", 32'(key_done), 32'd1);
        end
        chk("round_cnt_trace", 32'(trace_ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        key_in      = '0;
        key_valid   = 1'b0;
        rk_rd_idx   = '0;
        rk_rd_dec   = 1'b0;
        tb_rd_issue = 1'b0;
`ifdef SM4_KEY_ZEROIZE_EN
        key_zeroize = 1'b0;
`endif
        repeat (2) @(posedge clk_sys);
        #1;
        chk("rst_key_ready", 32'(key_ready), 32'd0);
        chk("rst_round_cnt", 32'(sm4_round_cnt), 32'd0);
        chk("rst_key_done", 32'(key_done), 32'd0);
        chk("rst_rd_data", rk_rd_data, 32'd0);
        @(negedge clk_sys);
        rst_n = 1'b1;
        @(posedge clk_sys);
        #1;
        chk("idle_key_ready", 32'(key_ready), 32'd1);

        // Standard vector, with an ignored key pulse mid-expansion
        model_expand(c_V1);
        send_key(c_V1);
        run_expand(1'b1);
        rd(5'd0,  1'b0, 32'hF12186F9, "std_rk0");
        rd(5'd31, 1'b0, 32'h9124A012, "std_rk31");
        rd(5'd0,  1'b1, 32'h9124A012, "dec_idx0");
        rd(5'd31, 1'b1, 32'hF12186F9, "dec_idx31");
        for (int i = 0; i < 32; i++) rd(5'(i), 1'b0, m_rk[i], $sformatf("fwd%0d", i));
        for (int i = 0; i < 32; i++) rd(5'(i), 1'b1, m_rk[31-i], $sformatf("dec%0d", i));
        rd_drain();

        // New key while DONE
        model_expand(c_V2);
        send_key(c_V2);
        chk("rekey_done_drop", 32'(key_done), 32'd0);
        run_expand(1'b0);
        for (int i = 0; i < 32; i++) rd(5'(i), 1'b0, m_rk[i], $sformatf("rekey%0d", i));
        rd_drain();

        // Reset in the middle of an expansion
        send_key(c_V3);
        repeat (19) @(posedge clk_sys);
        #1;
        rst_n = 1'b0;
        @(posedge clk_sys);
        #1;
        chk("midrst_key_done", 32'(key_done), 32'd0);
        chk("midrst_key_ready", 32'(key_ready), 32'd0);
        chk("midrst_round_cnt", 32'(sm4_round_cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge clk_sys);
        #1;
        chk("midrst_ready_back", 32'(key_ready), 32'd1);
        rd(5'd0,  1'b0, 32'd0, "midrst_mask0");
        rd(5'd31, 1'b1, 32'd0, "midrst_mask1");
        rd_drain();

        // Recovery with the standard vector
        model_expand(c_V1);
        send_key(c_V1);
        run_expand(1'b0);
        rd(5'd0, 1'b0, 32'hF12186F9, "again_rk0");
        rd(5'd5, 1'b1, m_rk[26], "again_dec5");
        rd_drain();

`ifdef SM4_KEY_ZEROIZE_EN
        @(negedge clk_sys);
        key_zeroize = 1'b1;
        @(posedge clk_sys);
        #1;
        key_zeroize = 1'b0;
        chk("zero_key_done", 32'(key_done), 32'd0);
        chk("zero_rd_data", rk_rd_data, 32'd0);
        force dut.r_key_done = 1'b1;
        for (int i = 0; i < 32; i++) rd(5'(i), 1'b0, 32'd0, $sformatf("zero%0d", i));
        rd_drain();
        release dut.r_key_done;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_sm4_key_expand
`default_nettype wire
